// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO result registers.
// One bit-serial datapath; a multiply or divide takes 32 iterations plus a commit
// cycle (33 cycles from start to done). Divide by zero commits in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B       operands (multiplicand/dividend, multiplier/divisor)
//   busy       operation in flight
//   done       one-cycle pulse after HI/LO are committed
//   hi, lo     HI/LO registers (upper product/remainder, lower product/quotient)
//   divByZero  sticky flag for the last divide with B == 0
//
// Build option: MULT_DIV_DIVIDE_EN enables the divider. Without it, divide
// requests are ignored and divByZero is tied low.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divByZero
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  state_t           state, state_nxt;
  logic             load, step, commit, accept;
  logic [CW-1:0]    cnt;
  logic [2*W-1:0]   acc;      // product accumulator / dividend-quotient shifter
  logic [W-1:0]     operand;  // multiplicand or divisor magnitude
  logic             neg_p;    // sign of product or quotient
  logic             signed_op;
  logic [W-1:0]     abs_a, abs_b;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   prod;

`ifdef MULT_DIV_DIVIDE_EN
  logic             div_q, dbz_q, neg_a, zero_div, quo_bit;
  logic [W-1:0]     rem, rem_nxt, quo, rem_out;
  logic [W:0]       rem_sh;
`endif

  // Operand conditioning: magnitudes for signed ops, raw values otherwise
  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op && A[W-1]) ? W'(-A) : A;
    abs_b     = (signed_op && B[W-1]) ? W'(-B) : B;
  end

  // Shift-add step: add multiplicand into upper half when current multiplier bit is set
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    prod    = neg_p ? (2*W)'(-acc) : acc;
  end

`ifdef MULT_DIV_DIVIDE_EN
  // Restoring-divide step on a 33-bit working remainder
  always_comb begin
    zero_div = op[1] && (B == '0);
    rem_sh   = {rem, acc[W-1]};
    quo_bit  = (rem_sh >= {1'b0, operand});
    rem_nxt  = quo_bit ? W'(rem_sh - {1'b0, operand}) : rem_sh[W-1:0];
    quo      = neg_p ? W'(-acc[W-1:0]) : acc[W-1:0];
    rem_out  = neg_a ? W'(-rem) : rem;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath controls
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
    accept    = start;
`else
    accept    = start && !op[1];
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = RUN;
`ifdef MULT_DIV_DIVIDE_EN
          if (zero_div) state_nxt = COMMIT;
`endif
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      neg_p   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULT_DIV_DIVIDE_EN
      div_q     <= 1'b0;
      dbz_q     <= 1'b0;
      neg_a     <= 1'b0;
      rem       <= '0;
      divByZero <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      done <= commit;
      if (load) begin
        cnt   <= '0;
        neg_p <= signed_op && (A[W-1] ^ B[W-1]);
`ifdef MULT_DIV_DIVIDE_EN
        div_q     <= op[1];
        dbz_q     <= zero_div;
        neg_a     <= signed_op && A[W-1];
        rem       <= '0;
        divByZero <= 1'b0;
        if (zero_div) begin
          acc     <= {A, {W{1'b1}}};
          operand <= '0;
        end else if (op[1]) begin
          acc     <= {{W{1'b0}}, abs_a};
          operand <= abs_b;
        end else begin
          acc     <= {{W{1'b0}}, abs_b};
          operand <= abs_a;
        end
`else
        acc     <= {{W{1'b0}}, abs_b};
        operand <= abs_a;
`endif
      end else if (step) begin
        cnt <= cnt + 1'b1;
`ifdef MULT_DIV_DIVIDE_EN
        if (div_q) begin
          rem            <= rem_nxt;
          acc[W-1:0]     <= {acc[W-2:0], quo_bit};
        end else begin
          acc <= {mul_sum, acc[W-1:1]};
        end
`else
        acc <= {mul_sum, acc[W-1:1]};
`endif
      end else if (commit) begin
`ifdef MULT_DIV_DIVIDE_EN
        if (dbz_q) begin
          hi        <= acc[2*W-1:W];
          lo        <= acc[W-1:0];
          divByZero <= 1'b1;
        end else if (div_q) begin
          hi <= rem_out;
          lo <= quo;
        end else begin
          hi <= prod[2*W-1:W];
          lo <= prod[W-1:0];
        end
`else
        hi <= prod[2*W-1:W];
        lo <= prod[W-1:0];
`endif
      end
    end
  end

`ifndef MULT_DIV_DIVIDE_EN
  assign divByZero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit; expected values are hand-computed.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one operation; returns cycles from the start edge to the first done.
  // When poke >= 0, a stray start with A=B=0 is raised at that RUN cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int poke, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 60) begin
      if (lat == poke) begin
        start = 1'b1; op = OP_MULTU; A = '0; B = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, " idle_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic expect_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e_hi,
                           input logic [31:0] e_lo, input int e_lat, input int poke);
    int lat;
    run_op(tag, o, a, b, poke, lat);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " hi"}, hi, e_hi);
    chk({tag, " lo"}, lo, e_lo);
  endtask

  initial begin
    int lat;
    int seen_busy;
    logic [31:0] hold_hi, hold_lo;

    // Reset values
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst dbz", 32'(divByZero), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Multiply cases
    expect_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1);
    @(posedge clk); #1;
    chk("done one cycle", 32'(done), 32'd0);
    expect_op("mult -3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 10);
    repeat (3) @(posedge clk); #1;
    chk("stray start ignored", 32'(busy), 32'd0);
    expect_op("mult minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, -1);
    expect_op("mult -1x-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, -1);
    expect_op("mult maxx-1", OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 33, -1);
    expect_op("multu shift", OP_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 33, -1);

    // Reset while running
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; A = 32'hFFFF_FFFF; B = 32'h3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    expect_op("multu 6x7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h2A, 33, -1);

`ifdef MULT_DIV_DIVIDE_EN
    expect_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 33, -1);
    expect_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1);
    expect_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33, -1);
    expect_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, -1);
    expect_op("div by zero", OP_DIV, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1, -1);
    chk("dbz flag", 32'(divByZero), 32'd1);
    run_op("multu 3x5", OP_MULTU, 32'd3, 32'd5, -1, lat);
    chk("dbz cleared", 32'(divByZero), 32'd0);
    chk("multu 3x5 lo", lo, 32'hF);
    chk("multu 3x5 hi", hi, 32'h0);
`else
    // Divide requests are dropped in this build
    hold_hi = hi; hold_lo = lo;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy || done) seen_busy++;
    end
    chk("divu ignored", 32'(seen_busy), 32'd0);
    chk("divu hi held", hi, hold_hi);
    chk("divu lo held", lo, hold_lo);
    chk("dbz tied", 32'(divByZero), 32'd0);
    expect_op("multu 3x5", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'hF, 33, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
